noise_checker: RTL and testbench

//  Receive-side checker for the 32-bit LFSR noise stream: self-synchronises to the incoming serial bits.

---
 rtl/noise_pkg.sv | 15 +
 rtl/lfsr_predictor.sv | 35 +++
 rtl/noise_checker.sv | 146 ++++++++++++++
 tb/tb_noise_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared definitions for the 32-bit LFSR noise generator and checker.
package noise_pkg;

   localparam int unsigned LFSR_W = 32;

   // Bit k-1 set adds x^k to the feedback polynomial (x^32 + ... + 1).
   localparam logic [LFSR_W-2:0] TAPS_DEFAULT = 31'b1100010;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

endpackage

// File: rtl/lfsr_predictor.sv
// Received-bit history register with combinational next-bit prediction.
module lfsr_predictor
   import noise_pkg::*;
#(
   parameter logic [LFSR_W-2:0] TAPS = TAPS_DEFAULT
)(
   input  logic clk,
   input  logic reset,
   input  logic shift,
   input  logic load_pred,
   input  logic bit_in,
   output logic pred,
   output logic h_zero
);

   // h[31-k] pairs with TAPS[k-1], so the tap mask is TAPS bit-reversed.
   localparam logic [LFSR_W-2:0] TAP_MASK = {<<{TAPS}};

   logic [LFSR_W-1:0] h_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_q <= '0;
      end else if (shift) begin
         h_q <= {h_q[LFSR_W-2:0], (load_pred ? pred : bit_in)};
      end
   end

   always_comb begin
      pred = h_q[LFSR_W-1] ^ (^(h_q[LFSR_W-2:0] & TAP_MASK));
   end

   assign h_zero = (h_q == '0);

endmodule

// File: rtl/noise_checker.sv
// LFSR noise stream checker: self-synchronises, then counts bit errors while locked.
module noise_checker
   import noise_pkg::*;
#(
   parameter logic [LFSR_W-2:0] TAPS        = TAPS_DEFAULT,
   parameter int unsigned       LOCK_COUNT  = 64,
   parameter int unsigned       WINDOW      = 256,
   parameter int unsigned       LOSS_THRESH = 8,
   parameter int unsigned       CNT_W       = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clear_counts,
   output logic             locked,
   output logic             error_pulse,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned FILL_W = $clog2(LFSR_W);
   localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);
   localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   chk_state_e        state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WERR_W-1:0] werr_q, werr_d, werr_inc;
   logic [CNT_W-1:0]  bit_cnt_d, err_cnt_d;
   logic              err_pulse_d;
   logic              load_pred;
   logic              pred;
   logic              h_zero;
   logic              mismatch;
   logic              win_end;

   lfsr_predictor #(
      .TAPS (TAPS)
   ) u_pred (
      .clk       (clk),
      .reset     (reset),
      .shift     (bit_valid),
      .load_pred (load_pred),
      .bit_in    (bit_in),
      .pred      (pred),
      .h_zero    (h_zero)
   );

   assign mismatch = (pred != bit_in);
   assign win_end  = (win_q == WIN_W'(WINDOW - 1));
   assign werr_inc = werr_q + WERR_W'(1);

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= FILL;
         fill_q      <= '0;
         run_q       <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         locked      <= 1'b0;
         error_pulse <= 1'b0;
         bit_count   <= '0;
         err_count   <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         run_q       <= run_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         locked      <= (state_d == LOCKED);
         error_pulse <= err_pulse_d;
         bit_count   <= bit_cnt_d;
         err_count   <= err_cnt_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      run_d       = run_q;
      win_d       = win_q;
      werr_d      = werr_q;
      bit_cnt_d   = bit_count;
      err_cnt_d   = err_count;
      err_pulse_d = 1'b0;
      load_pred   = (state_q == LOCKED);

      if (bit_valid) begin
         unique case (state_q)
            FILL: begin
               if (fill_q == FILL_W'(LFSR_W - 1)) begin
                  fill_d  = '0;
                  state_d = SEARCH;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end
            SEARCH: begin
               // An all-zero history would predict a dead line as valid.
               if (mismatch || h_zero) begin
                  run_d = '0;
               end else if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                  run_d   = '0;
                  win_d   = '0;
                  werr_d  = '0;
                  state_d = LOCKED;
               end else begin
                  run_d = run_q + RUN_W'(1);
               end
            end
            LOCKED: begin
               if (bit_count != '1) bit_cnt_d = bit_count + CNT_W'(1);
               win_d = win_end ? '0 : (win_q + WIN_W'(1));
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count != '1) err_cnt_d = err_count + CNT_W'(1);
               end
               if (mismatch && (werr_inc == WERR_W'(LOSS_THRESH))) begin
                  run_d   = '0;
                  win_d   = '0;
                  werr_d  = '0;
                  state_d = SEARCH;
               end else if (win_end) begin
                  werr_d = '0;
               end else if (mismatch) begin
                  werr_d = werr_inc;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end

      if (clear_counts) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

endmodule

// File: tb/tb_noise_checker.sv
// Directed self-checking bench for noise_checker driven by a reference LFSR stream.
module tb_noise_checker;

   logic        clk;
   logic        reset;
   logic        bit_valid;
   logic        bit_in;
   logic        clear_counts;
   logic        locked;
   logic        error_pulse;
   logic [31:0] bit_count;
   logic [31:0] err_count;

   int unsigned checks;
   int unsigned failures;
   logic [31:0] g;

   noise_checker dut (
      .clk          (clk),
      .reset        (reset),
      .bit_valid    (bit_valid),
      .bit_in       (bit_in),
      .clear_counts (clear_counts),
      .locked       (locked),
      .error_pulse  (error_pulse),
      .bit_count    (bit_count),
      .err_count    (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference generator: x^32 + x^7 + x^6 + x^2 + 1, newest bit at g[0]
   task automatic next_bit(output logic b);
      b = g[31] ^ g[29] ^ g[25] ^ g[24];
      g = {g[30:0], b};
   endtask

   task automatic step(input logic v, input logic b, input logic clr);
      bit_valid    = v;
      bit_in       = b;
      clear_counts = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic        b;
      logic        bad;
      int unsigned nv;

      checks       = 0;
      failures     = 0;
      g            = 32'hACE1_2468;
      reset        = 1'b0;
      bit_valid    = 1'b0;
      bit_in       = 1'b0;
      clear_counts = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_pulse",  32'(error_pulse), 32'd0);
      chk("rst_bc",     bit_count, 32'd0);
      chk("rst_ec",     err_count, 32'd0);
      reset = 1'b1;

      // Clean stream: lock after 96th valid bit, then 10000 total without errors
      bad = 1'b0;
      for (int i = 1; i <= 10000; i++) begin
         next_bit(b);
         step(1'b1, b, 1'b0);
         if (i == 95) chk("t1_prelock", 32'(locked), 32'd0);
         if (i == 96) begin
            chk("t1_lock",    32'(locked), 32'd1);
            chk("t1_bc_lock", bit_count, 32'd0);
         end
         if (i > 96 && (error_pulse || !locked)) bad = 1'b1;
      end
      chk("t1_clean", 32'(bad), 32'd0);
      chk("t1_ec",    err_count, 32'd0);
      chk("t1_bc",    bit_count, 32'd9904);

      // Single inverted bit: counted once, no propagation
      next_bit(b);
      step(1'b1, ~b, 1'b0);
      chk("t2_pulse",  32'(error_pulse), 32'd1);
      chk("t2_ec",     err_count, 32'd1);
      chk("t2_locked", 32'(locked), 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 31; i++) begin
         next_bit(b);
         step(1'b1, b, 1'b0);
         if (i == 0) chk("t2_pulse_drop", 32'(error_pulse), 32'd0);
         if (error_pulse) bad = 1'b1;
      end
      chk("t2_no_prop", 32'(bad), 32'd0);
      chk("t2_ec_hold", err_count, 32'd1);

      // Clear on an idle cycle, then error bursts around a window boundary
      step(1'b0, 1'b0, 1'b1);
      chk("t3_clr_ec", err_count, 32'd0);
      chk("t3_clr_bc", bit_count, 32'd0);
      for (int i = 0; i < 42; i++) begin
         next_bit(b);
         step(1'b1, b, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         next_bit(b);
         step(1'b1, ~b, 1'b0);
      end
      chk("t3_win_end_locked", 32'(locked), 32'd1);
      chk("t3_win_end_ec",     err_count, 32'd6);
      for (int i = 0; i < 7; i++) begin
         next_bit(b);
         step(1'b1, ~b, 1'b0);
      end
      chk("t3_seven_locked", 32'(locked), 32'd1);
      next_bit(b);
      step(1'b1, ~b, 1'b0);
      chk("t3_loss",    32'(locked), 32'd0);
      chk("t3_loss_ec", err_count, 32'd14);
      chk("t3_loss_bc", bit_count, 32'd56);
      for (int i = 0; i < 63; i++) begin
         next_bit(b);
         step(1'b1, b, 1'b0);
      end
      chk("t3_prerelock", 32'(locked), 32'd0);
      next_bit(b);
      step(1'b1, b, 1'b0);
      chk("t3_relock",    32'(locked), 32'd1);
      chk("t3_relock_ec", err_count, 32'd14);
      chk("t3_relock_bc", bit_count, 32'd56);

      // Clear coinciding with an error: clear wins
      next_bit(b);
      step(1'b1, ~b, 1'b1);
      chk("t5_clr_err_ec",     err_count, 32'd0);
      chk("t5_clr_err_bc",     bit_count, 32'd0);
      chk("t5_clr_err_pulse",  32'(error_pulse), 32'd1);
      chk("t5_clr_err_locked", 32'(locked), 32'd1);

      // Reset while locked with errors recorded
      for (int i = 0; i < 5; i++) begin
         next_bit(b);
         step(1'b1, ~b, 1'b0);
      end
      chk("t6_pre_ec",     err_count, 32'd5);
      chk("t6_pre_locked", 32'(locked), 32'd1);
      reset = 1'b0;
      next_bit(b);
      step(1'b1, b, 1'b0);
      chk("t6_rst_locked", 32'(locked), 32'd0);
      chk("t6_rst_ec",     err_count, 32'd0);
      chk("t6_rst_bc",     bit_count, 32'd0);
      chk("t6_rst_pulse",  32'(error_pulse), 32'd0);
      reset = 1'b1;

      // Stuck-low then stuck-high lines never lock
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (locked || error_pulse || bit_count != 0 || err_count != 0) bad = 1'b1;
      end
      chk("t4_stuck0", 32'(bad), 32'd0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (locked || error_pulse || bit_count != 0 || err_count != 0) bad = 1'b1;
      end
      chk("t4_stuck1", 32'(bad), 32'd0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      // Random valid gaps: lock after 96 valid bits, then clean counting
      nv = 0;
      while (nv < 96) begin
         if ($urandom_range(0, 1) == 1) begin
            nv++;
            next_bit(b);
            step(1'b1, b, 1'b0);
            if (nv == 95) chk("t5_gap_prelock", 32'(locked), 32'd0);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      chk("t5_gap_lock", 32'(locked), 32'd1);
      nv  = 0;
      bad = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            nv++;
            next_bit(b);
            step(1'b1, b, 1'b0);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         if (error_pulse || !locked) bad = 1'b1;
      end
      chk("t5_gap_clean", 32'(bad), 32'd0);
      chk("t5_gap_bc",    bit_count, nv);
      chk("t5_gap_ec",    err_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
